// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch FSM driving a synchronous one-cycle-latency RAM port.
// Optional halt-word detection is enabled with `define FETCH_HALT_DETECT_EN.
`default_nettype none

module fetch_unit #(
   parameter int ADDR_WIDTH = 8,
   parameter int INST_WIDTH = 16
) (
   input  logic                  Clk,
   input  logic                  Rst,
   input  logic                  Fetch_En,
   input  logic                  Branch_Take,
   input  logic [ADDR_WIDTH-1:0] Branch_Addr,
   input  logic [INST_WIDTH-1:0] Ram_Inst_Out,
   output logic                  Ram_Inst_Read,
   output logic [ADDR_WIDTH-1:0] Inst_Addr,
   output logic [INST_WIDTH-1:0] Inst_Out,
   output logic [ADDR_WIDTH-1:0] Inst_PC,
   output logic                  Inst_Valid,
   input  logic                  Inst_Ready,
   output logic                  Halted
);

`ifdef FETCH_HALT_DETECT_EN
   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_REQ  = 3'd1,
      S_WAIT = 3'd2,
      S_HOLD = 3'd3,
      S_HALT = 3'd4
   } state_t;
`else
   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_REQ  = 3'd1,
      S_WAIT = 3'd2,
      S_HOLD = 3'd3
   } state_t;
`endif

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic [INST_WIDTH-1:0] inst_out_q, inst_out_d;
   logic [ADDR_WIDTH-1:0] inst_pc_q, inst_pc_d;
   logic                  accept;

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state_q    <= S_IDLE;
         pc_q       <= '0;
         inst_out_q <= '0;
         inst_pc_q  <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         inst_out_q <= inst_out_d;
         inst_pc_q  <= inst_pc_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      inst_out_d = inst_out_q;
      inst_pc_d  = inst_pc_q;
      accept     = (state_q == S_HOLD) && Inst_Ready;

      case (state_q)
         S_IDLE: begin
            if (Fetch_En) state_d = S_REQ;
         end
         S_REQ: begin
            state_d = S_WAIT;
         end
         S_WAIT: begin
            inst_out_d = Ram_Inst_Out;
            inst_pc_d  = pc_q;
            pc_d       = pc_q + ADDR_WIDTH'(1);
            state_d    = S_HOLD;
         end
         S_HOLD: begin
            if (accept) begin
`ifdef FETCH_HALT_DETECT_EN
               if (&inst_out_q) state_d = S_HALT;
               else             state_d = Fetch_En ? S_REQ : S_IDLE;
`else
               state_d = Fetch_En ? S_REQ : S_IDLE;
`endif
            end
         end
`ifdef FETCH_HALT_DETECT_EN
         S_HALT: begin
            state_d = S_HALT;
         end
`endif
         default: state_d = S_IDLE;
      endcase

      // A redirect overrides everything, including a capture still in flight.
      if (Branch_Take) begin
         pc_d       = Branch_Addr;
         inst_out_d = inst_out_q;
         inst_pc_d  = inst_pc_q;
         state_d    = Fetch_En ? S_REQ : S_IDLE;
      end
   end

   assign Ram_Inst_Read = (state_q == S_REQ);
   assign Inst_Addr     = pc_q;
   assign Inst_Out      = inst_out_q;
   assign Inst_PC       = inst_pc_q;
   assign Inst_Valid    = (state_q == S_HOLD);
`ifdef FETCH_HALT_DETECT_EN
   assign Halted        = (state_q == S_HALT);
`else
   assign Halted        = 1'b0;
`endif

endmodule

`default_nettype wire

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, width of the program counter and of Inst_Addr.
REQ-002 Parameter INST_WIDTH, default 16, width of an instruction word.
REQ-003 Clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Rst  input  1  asynchronous, active-high reset.
REQ-005 Fetch_En  input  1  high: fetching permitted.
REQ-006 Branch_Take  input  1  one-cycle redirect strobe.
REQ-007 Branch_Addr  input  ADDR_WIDTH  redirect target.
REQ-008 Ram_Inst_Out  input  INST_WIDTH  instruction word from the RAM instruction port.
REQ-009 Ram_Inst_Read  output  1  RAM instruction read strobe.
REQ-010 Inst_Addr  output  ADDR_WIDTH  RAM instruction address.
REQ-011 Inst_Out  output  INST_WIDTH  registered instruction to the decoder.
REQ-012 Inst_PC  output  ADDR_WIDTH  address of Inst_Out.
REQ-013 Inst_Valid  output  1  Inst_Out/Inst_PC valid.
REQ-014 Inst_Ready  input  1  decoder accepts when Inst_Valid and Inst_Ready are both high at a rising edge.
REQ-015 Halted  output  1  fetch stopped on a halt word.

Function
REQ-016 RAM contract: Ram_Inst_Out SHALL be sampled exactly one cycle after the cycle in which Ram_Inst_Read=1 was presented with Inst_Addr.
REQ-017 FSM states SHALL be IDLE, REQ, WAIT, HOLD and HALT.
- IDLE: Fetch_En=1 -> REQ; otherwise stay.
- REQ: Ram_Inst_Read=1, Inst_Addr=PC; -> WAIT.
- WAIT: Inst_Out<=Ram_Inst_Out, Inst_PC<=PC, PC<=PC+1; -> HOLD.
- HOLD: Inst_Valid=1; on accept -> REQ if Fetch_En=1, else IDLE.
REQ-018 Ram_Inst_Read SHALL be high only in REQ; Inst_Addr SHALL equal PC in all states.
REQ-019 Inst_Out and Inst_PC SHALL remain stable while Inst_Valid=1 and Inst_Ready=0.
REQ-020 Steady-state throughput SHALL be one instruction per 3 cycles with Inst_Ready held high.
REQ-021 PC increment SHALL wrap from 2^ADDR_WIDTH-1 to 0.
REQ-022 Branch_Take=1 in any state SHALL set PC<=Branch_Addr, drop Inst_Valid on the next edge, discard any in-flight read, and go to REQ if Fetch_En=1, else IDLE.
REQ-023 Branch_Take SHALL take priority over a simultaneous accept; the accepted word is still consumed by the decoder, but no further fetch from the old stream occurs.
REQ-024 Fetch_En deasserted in REQ or WAIT SHALL NOT abort the fetch; the word reaches HOLD and the FSM returns to IDLE after its accept.

Reset
REQ-025 Rst=1 SHALL immediately force: state IDLE, PC=0, Inst_Out=0, Inst_PC=0, Inst_Valid=0, Ram_Inst_Read=0, Halted=0.
REQ-026 Rst asserted mid-fetch SHALL discard the in-flight word; the first fetch after release SHALL be from address 0.

Configuration
REQ-027 Macro FETCH_HALT_DETECT_EN defined: a captured all-ones word SHALL be presented normally; after its accept the FSM SHALL enter HALT with Halted=1, issuing no reads until Rst or Branch_Take (Branch_Take exits HALT per REQ-022 and clears Halted).
REQ-028 Macro FETCH_HALT_DETECT_EN undefined: the HALT state SHALL be absent, an all-ones word SHALL be treated as ordinary, and Halted SHALL be tied to 0.

Verification
REQ-029 Reset release, Fetch_En=1, Inst_Ready=1, RAM[0..2]=16'h1111/2222/3333 -> three accepts with Inst_PC 0,1,2 at 3-cycle spacing; Ram_Inst_Read high one cycle in three.
REQ-030 Inst_Ready=0 for 5 cycles while in HOLD -> Inst_Out/Inst_PC unchanged, no Ram_Inst_Read pulses; the word is accepted on the first Inst_Ready=1 edge.
REQ-031 Branch_Take with Branch_Addr=8'h40 during WAIT at PC=5 -> the word at address 5 is never valid; the next valid word has Inst_PC=8'h40.
REQ-032 PC=8'hFF fetch -> Inst_PC=8'hFF, next Inst_PC=8'h00.
REQ-033 Rst pulse during WAIT -> all outputs are 0 in the same cycle; after release, the first Inst_Addr is 0.
REQ-034 FETCH_HALT_DETECT_EN, RAM[3]=16'hFFFF -> word 3 is accepted, Halted=1, no further reads; Branch_Take to 0 resumes fetching with Halted=0.
